// File: rtl/thermostat_sequencer.sv
// Temperature control loop that time-shares one external comparator.
// Three comparisons per sample feed a dwell-protected heat/cool decision.
module thermostat_sequencer #(
    parameter int BIT_WIDTH   = 8,
    parameter int MIN_DWELL   = 16,
    parameter int ALARM_COUNT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 temp_valid,
    input  logic [BIT_WIDTH-1:0] temp_data,
    input  logic [BIT_WIDTH-1:0] setpoint,
    input  logic [BIT_WIDTH-1:0] hysteresis,
    output logic [BIT_WIDTH-1:0] cmp_a,
    output logic [BIT_WIDTH-1:0] cmp_b,
    input  logic                 cmp_gt,
    input  logic                 cmp_eq,
    input  logic                 cmp_lt,
    output logic                 ready,
    output logic                 heater_on,
    output logic                 cooler_on,
    output logic                 alarm,
    output logic                 done,
    output logic                 sample_dropped
);

    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int AW = $clog2(ALARM_COUNT + 1);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(MIN_DWELL);
    localparam logic [AW-1:0] ALARM_MAX  = AW'(ALARM_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMP_LO,
        S_CMP_SP,
        S_CMP_HI,
        S_DECIDE
    } state_t;

    typedef enum logic [1:0] {
        M_OFF,
        M_HEAT,
        M_COOL
    } mode_t;

    state_t state_q, state_d;
    mode_t  mode_q, mode_d, req_mode;

    logic [BIT_WIDTH-1:0] temp_q, sp_q, hyst_q;
    logic [BIT_WIDTH-1:0] low_th, high_th;
    logic [BIT_WIDTH:0]   lo_diff, hi_sum;
    logic                 below_lo, ge_sp, le_sp, above_hi;
    logic [DW-1:0]        dwell_q, dwell_d, dwell_dec;
    logic [AW-1:0]        acnt_q, acnt_d;
    logic                 accept;

    // Thresholds are widened by one bit so the borrow/carry drives the clamp.
    assign lo_diff = {1'b0, sp_q} - {1'b0, hyst_q};
    assign hi_sum  = {1'b0, sp_q} + {1'b0, hyst_q};
    assign low_th  = lo_diff[BIT_WIDTH] ? '0 : lo_diff[BIT_WIDTH-1:0];
    assign high_th = hi_sum[BIT_WIDTH] ? '1 : hi_sum[BIT_WIDTH-1:0];

    assign heater_on = (mode_q == M_HEAT);
    assign cooler_on = (mode_q == M_COOL);
    assign accept    = (state_q == S_IDLE) && temp_valid && enable;

    always_comb begin
        state_d = state_q;
        cmp_a   = '0;
        cmp_b   = '0;
        ready   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (accept) state_d = S_CMP_LO;
            end
            S_CMP_LO: begin
                cmp_a   = temp_q;
                cmp_b   = low_th;
                state_d = S_CMP_SP;
            end
            S_CMP_SP: begin
                cmp_a   = temp_q;
                cmp_b   = sp_q;
                state_d = S_CMP_HI;
            end
            S_CMP_HI: begin
                cmp_a   = temp_q;
                cmp_b   = high_th;
                state_d = S_DECIDE;
            end
            S_DECIDE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (!enable) state_d = S_IDLE;
    end

    always_comb begin
        req_mode = mode_q;
        unique case (mode_q)
            M_OFF: begin
                if (below_lo)      req_mode = M_HEAT;
                else if (above_hi) req_mode = M_COOL;
            end
            M_HEAT:  if (ge_sp) req_mode = M_OFF;
            M_COOL:  if (le_sp) req_mode = M_OFF;
            default: req_mode = M_OFF;
        endcase
    end

    always_comb begin
        dwell_dec = (dwell_q == '0) ? '0 : dwell_q - DW'(1);
        mode_d    = mode_q;
        dwell_d   = dwell_dec;
        acnt_d    = acnt_q;
        if (state_q == S_DECIDE) begin
            // A blocked request is dropped; the next sample re-raises it.
            if (req_mode != mode_q && dwell_q == '0) begin
                mode_d  = req_mode;
                dwell_d = DWELL_LOAD;
            end
            if (below_lo || above_hi)
                acnt_d = (acnt_q == ALARM_MAX) ? acnt_q : acnt_q + AW'(1);
            else
                acnt_d = '0;
        end
        if (!enable) begin
            mode_d  = M_OFF;
            dwell_d = '0;
            acnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            mode_q         <= M_OFF;
            dwell_q        <= '0;
            acnt_q         <= '0;
            alarm          <= 1'b0;
            done           <= 1'b0;
            sample_dropped <= 1'b0;
            temp_q         <= '0;
            sp_q           <= '0;
            hyst_q         <= '0;
            below_lo       <= 1'b0;
            ge_sp          <= 1'b0;
            le_sp          <= 1'b0;
            above_hi       <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            dwell_q        <= dwell_d;
            acnt_q         <= acnt_d;
            alarm          <= (acnt_d == ALARM_MAX);
            done           <= enable && (state_q == S_DECIDE);
            sample_dropped <= temp_valid && !(state_q == S_IDLE && enable);
            if (accept) begin
                temp_q <= temp_data;
                sp_q   <= setpoint;
                hyst_q <= hysteresis;
            end
            if (state_q == S_CMP_LO) below_lo <= cmp_lt;
            if (state_q == S_CMP_SP) begin
                ge_sp <= cmp_gt | cmp_eq;
                le_sp <= cmp_lt | cmp_eq;
            end
            if (state_q == S_CMP_HI) above_hi <= cmp_gt;
        end
    end

endmodule

// File: tb/tb_thermostat_sequencer.sv
// Randomized bench for thermostat_sequencer against a behavioural model.
// The external comparator is modelled here as plain relational operators.
module tb_thermostat_sequencer;

    localparam int BW = 8;
    localparam int MIN_DWELL = 16;
    localparam int ALARM_COUNT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          temp_valid = 1'b0;
    logic [BW-1:0] temp_data = '0;
    logic [BW-1:0] setpoint = '0;
    logic [BW-1:0] hysteresis = '0;
    logic [BW-1:0] cmp_a, cmp_b;
    logic          cmp_gt, cmp_eq, cmp_lt;
    logic          ready, heater_on, cooler_on, alarm, done;
    logic          sample_dropped;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Model state: mode 0=OFF 1=HEAT 2=COOL, edge of last change, alarm run
    int m_mode = 0;
    int m_last = -1000;
    int m_acnt = 0;

    thermostat_sequencer #(
        .BIT_WIDTH(BW),
        .MIN_DWELL(MIN_DWELL),
        .ALARM_COUNT(ALARM_COUNT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .temp_valid(temp_valid),
        .temp_data(temp_data),
        .setpoint(setpoint),
        .hysteresis(hysteresis),
        .cmp_a(cmp_a),
        .cmp_b(cmp_b),
        .cmp_gt(cmp_gt),
        .cmp_eq(cmp_eq),
        .cmp_lt(cmp_lt),
        .ready(ready),
        .heater_on(heater_on),
        .cooler_on(cooler_on),
        .alarm(alarm),
        .done(done),
        .sample_dropped(sample_dropped)
    );

    assign cmp_gt = cmp_a > cmp_b;
    assign cmp_eq = cmp_a == cmp_b;
    assign cmp_lt = cmp_a < cmp_b;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_last = -1000;
        m_acnt = 0;
    endtask

    function automatic int lo_of(input int sp, input int hy);
        return (sp > hy) ? sp - hy : 0;
    endfunction

    function automatic int hi_of(input int sp, input int hy);
        return (sp + hy > 255) ? 255 : sp + hy;
    endfunction

    task automatic model_decide(input int t, input int sp, input int hy,
                                input int d);
        int lo, hi, req;
        bit below, above;
        lo = lo_of(sp, hy);
        hi = hi_of(sp, hy);
        below = t < lo;
        above = t > hi;
        req = m_mode;
        if (m_mode == 0) req = below ? 1 : (above ? 2 : 0);
        else if (m_mode == 1) req = (t >= sp) ? 0 : 1;
        else req = (t <= sp) ? 0 : 2;
        if (req != m_mode && (d - m_last) > MIN_DWELL) begin
            m_mode = req;
            m_last = d;
        end
        if (below || above)
            m_acnt = (m_acnt < ALARM_COUNT) ? m_acnt + 1 : ALARM_COUNT;
        else
            m_acnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_heat"}, heater_on, m_mode == 1);
        check({tag, "_cool"}, cooler_on, m_mode == 2);
        check({tag, "_alarm"}, alarm, m_acnt == ALARM_COUNT);
    endtask

    task automatic run_sample(input int t, input int sp, input int hy,
                              input bit drop);
        int lo, hi;
        for (int i = 0; i < 8 && !ready; i++) step();
        check("ready_wait", ready, 1);
        lo = lo_of(sp, hy);
        hi = hi_of(sp, hy);
        enable = 1'b1;
        temp_valid = 1'b1;
        temp_data = BW'(t);
        setpoint = BW'(sp);
        hysteresis = BW'(hy);
        step();
        temp_valid = 1'b0;
        setpoint = BW'($urandom);
        hysteresis = BW'($urandom);
        check("busy", ready, 0);
        check("lo_a", cmp_a, t);
        check("lo_b", cmp_b, lo);
        step();
        check("sp_a", cmp_a, t);
        check("sp_b", cmp_b, sp);
        if (drop) begin
            temp_valid = 1'b1;
            temp_data = BW'($urandom);
        end
        step();
        temp_valid = 1'b0;
        check("dropped", sample_dropped, drop);
        check("hi_a", cmp_a, t);
        check("hi_b", cmp_b, hi);
        step();
        check("decide_done", done, 0);
        check("decide_a", cmp_a, 0);
        step();
        model_decide(t, sp, hy, edge_n);
        check("done", done, 1);
        check("ready_after", ready, 1);
        check_outputs("decide");
    endtask

    task automatic abort_pulse();
        enable = 1'b0;
        step();
        model_reset();
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check_outputs("abort");
        enable = 1'b1;
    endtask

    initial begin
        int sp, hy, t, gap;
        #3;
        check("rst_ready", ready, 1);
        check("rst_heat", heater_on, 0);
        check("rst_cool", cooler_on, 0);
        check("rst_alarm", alarm, 0);
        check("rst_done", done, 0);
        check("rst_drop", sample_dropped, 0);
        check("rst_cmp", cmp_a | cmp_b, 0);
        rst_n = 1'b1;
        enable = 1'b1;
        step();

        // Heat on, dwell hold, dwell release, cool after dwell
        run_sample(90, 100, 5, 0);
        run_sample(101, 100, 5, 0);
        repeat (20) step();
        run_sample(101, 100, 5, 0);
        run_sample(110, 100, 5, 0);
        repeat (16) step();
        run_sample(110, 100, 5, 0);

        // Alarm persistence and clear
        repeat (4) run_sample(120, 100, 5, 0);
        run_sample(100, 100, 5, 0);

        // Saturated thresholds stay OFF at the rails
        abort_pulse();
        run_sample(255, 250, 10, 0);
        run_sample(0, 3, 10, 0);

        // Sample offered mid-sequence is dropped
        run_sample(90, 100, 5, 1);

        // Disable while heating
        abort_pulse();
        run_sample(90, 100, 5, 0);
        abort_pulse();

        // Abort mid-sequence: no done pulse
        temp_valid = 1'b1;
        temp_data = 8'd90;
        setpoint = 8'd100;
        hysteresis = 8'd5;
        step();
        temp_valid = 1'b0;
        step();
        enable = 1'b0;
        step();
        model_reset();
        check("midabort_ready", ready, 1);
        check("midabort_cmp", cmp_a, 0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("midabort_nodone", done, 0);
        end

        // Reset while in CMP_SP
        temp_valid = 1'b1;
        step();
        temp_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_ready", ready, 1);
        check("arst_cmp", cmp_a | cmp_b, 0);
        check("arst_done", done, 0);
        check_outputs("arst");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("arst_nodone", done, 0);
        end

        // Random samples around random bands
        for (int n = 0; n < 150; n++) begin
            sp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                             : $urandom_range(40, 200);
            hy = $urandom_range(0, 20);
            t = sp + $urandom_range(0, 4 * hy + 8) - (2 * hy + 4);
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            run_sample(t, sp, hy, $urandom_range(0, 3) == 0);
            gap = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 20);
            for (int i = 0; i < gap; i++) begin
                step();
                if (i == 0) check("gap_nodone", done, 0);
            end
            if ($urandom_range(0, 24) == 0) abort_pulse();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
